// File: rtl/yutorina_bus_arbiter_pkg.sv
// Shared definitions for the system-bus arbiter: owner width, state encodings
// and helpers for the packed per-master address/data vectors.
package yutorina_bus_arbiter_pkg;

   localparam int BUS_OWNER_W = 2;
   localparam int BUS_MAX_M   = 4;

   typedef logic [BUS_OWNER_W-1:0] bus_owner_t;

   typedef enum logic [0:0] {
      BUS_IDLE  = 1'b0,
      BUS_OWNED = 1'b1
   } bus_state_e;

   localparam logic [BUS_MAX_M-1:0] BUS_GRANT_NONE = 4'b1111;

   // Low bit of master idx's slice in a packed per-master vector.
   function automatic int bus_slice_lo(input int idx, input int width);
      return idx * width;
   endfunction

   function automatic logic [BUS_MAX_M-1:0] bus_onehot(input bus_owner_t idx);
      logic [BUS_MAX_M-1:0] vec;
      vec = 4'b0000;
      vec[idx] = 1'b1;
      return vec;
   endfunction

endpackage

// File: rtl/yutorina_rr_pick.sv
// Combinational round-robin search: first requesting master at or after
// start, wrapping modulo NUM_M.
module yutorina_rr_pick
   import yutorina_bus_arbiter_pkg::*;
#(
   parameter int NUM_M = 4
) (
   input  logic [NUM_M-1:0] req,
   input  bus_owner_t       start,
   output bus_owner_t       winner,
   output logic             valid
);

   logic [BUS_MAX_M-1:0] req_pad_s;
   bus_owner_t           idx_s;
   int                   sum_s;

   // Scan NUM_M positions from start and keep the first hit.
   always_comb begin
      req_pad_s = BUS_MAX_M'(req);
      winner    = '0;
      valid     = 1'b0;
      idx_s     = '0;
      sum_s     = 0;
      for (int k = 0; k < NUM_M; k++) begin
         sum_s = int'(start) + k;
         if (sum_s >= NUM_M) begin
            sum_s = sum_s - NUM_M;
         end else begin
            sum_s = sum_s;
         end
         idx_s = BUS_OWNER_W'(sum_s);
         if (!valid && req_pad_s[idx_s]) begin
            valid  = 1'b1;
            winner = idx_s;
         end else begin
            valid  = valid;
         end
      end
   end

endmodule

// File: rtl/yutorina_bus_arbiter.sv
// Round-robin arbiter and address/control multiplexer for the shared system
// bus, using the active-low req_/grnt_/as_/rdy_ handshake.
module yutorina_bus_arbiter
   import yutorina_bus_arbiter_pkg::*;
#(
   parameter int NUM_M    = 4,
   parameter int ADDR_W   = 30,
   parameter int DATA_W   = 32,
   parameter int MAX_HOLD = 0
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [NUM_M-1:0]          m_req_,
   output logic [NUM_M-1:0]          m_grnt_,
   input  logic [NUM_M*ADDR_W-1:0]   m_addr,
   input  logic [NUM_M-1:0]          m_as_,
   input  logic [NUM_M-1:0]          m_rw,
   input  logic [NUM_M*DATA_W-1:0]   m_w_data,
   output logic [NUM_M-1:0]          m_rdy_,
   output logic [ADDR_W-1:0]         s_addr,
   output logic                      s_as_,
   output logic                      s_rw,
   output logic [DATA_W-1:0]         s_w_data,
   input  logic                      s_rdy_,
   output logic [BUS_OWNER_W-1:0]    owner,
   output logic                      busy
);

   localparam int HOLD_W = (MAX_HOLD < 1) ? 1 : $clog2(MAX_HOLD + 1);
   localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MAX_HOLD);

   bus_state_e           state_r, state_s;
   bus_owner_t           owner_r, owner_s;
   logic [NUM_M-1:0]     grnt_r, grnt_s;
   logic [HOLD_W-1:0]    hold_r, hold_s;

   logic [BUS_MAX_M-1:0] req_pad_s, as_pad_s, owner_hot_s, next_hot_s;
   logic                 owner_req_s, others_s, hold_expired_s, pick_valid_s;
   bus_owner_t           start_s, pick_s;

   // Request/strobe views padded to the full owner range; absent masters never request.
   always_comb begin
      req_pad_s   = BUS_MAX_M'(~m_req_);
      as_pad_s    = ~BUS_MAX_M'(~m_as_);
      owner_hot_s = bus_onehot(owner_r);
      owner_req_s = req_pad_s[owner_r];
      others_s    = |(req_pad_s & ~owner_hot_s);
      if (owner_r == BUS_OWNER_W'(NUM_M - 1)) begin
         start_s = '0;
      end else begin
         start_s = owner_r + 2'd1;
      end
      hold_expired_s = (MAX_HOLD > 0) && (hold_r >= HOLD_MAX) && as_pad_s[owner_r] && others_s;
   end

   yutorina_rr_pick #(
      .NUM_M (NUM_M)
   ) u_pick (
      .req    (~m_req_),
      .start  (start_s),
      .winner (pick_s),
      .valid  (pick_valid_s)
   );

   // State, owner, grant and hold-counter registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= BUS_IDLE;
         owner_r <= '0;
         grnt_r  <= '1;
         hold_r  <= '0;
      end else begin
         state_r <= state_s;
         owner_r <= owner_s;
         grnt_r  <= grnt_s;
         hold_r  <= hold_s;
      end
   end

   // Next-state: the owner is searched last, so any hand-over picks another master.
   always_comb begin
      state_s = state_r;
      owner_s = owner_r;
      hold_s  = hold_r;
      case (state_r)
         BUS_IDLE: begin
            if (pick_valid_s) begin
               state_s = BUS_OWNED;
               owner_s = pick_s;
               hold_s  = '0;
            end else begin
               state_s = BUS_IDLE;
            end
         end
         BUS_OWNED: begin
            if (owner_req_s && !hold_expired_s) begin
               if (others_s && (hold_r < HOLD_MAX)) begin
                  hold_s = hold_r + HOLD_W'(1);
               end else begin
                  hold_s = hold_r;
               end
            end else if (others_s) begin
               owner_s = pick_s;
               hold_s  = '0;
            end else begin
               state_s = BUS_IDLE;
               hold_s  = '0;
            end
         end
         default: begin
            state_s = BUS_IDLE;
            hold_s  = '0;
         end
      endcase
      next_hot_s = bus_onehot(owner_s);
      if (state_s == BUS_OWNED) begin
         grnt_s = ~next_hot_s[NUM_M-1:0];
      end else begin
         grnt_s = BUS_GRANT_NONE[NUM_M-1:0];
      end
   end

   // Slave-side mux and ready return; idle bus parks at a neutral read.
   always_comb begin
      s_addr   = '0;
      s_w_data = '0;
      s_rw     = 1'b1;
      s_as_    = 1'b1;
      m_rdy_   = '1;
      if (state_r == BUS_OWNED) begin
         for (int i = 0; i < NUM_M; i++) begin
            if (owner_r == BUS_OWNER_W'(i)) begin
               s_addr    = m_addr[bus_slice_lo(i, ADDR_W) +: ADDR_W];
               s_w_data  = m_w_data[bus_slice_lo(i, DATA_W) +: DATA_W];
               s_rw      = m_rw[i];
               s_as_     = m_as_[i];
               m_rdy_[i] = s_rdy_;
            end else begin
               m_rdy_[i] = 1'b1;
            end
         end
      end else begin
         s_as_ = 1'b1;
      end
   end

   assign m_grnt_ = grnt_r;
   assign owner   = owner_r;
   assign busy    = (state_r == BUS_OWNED);

endmodule

// File: tb/tb_yutorina_bus_arbiter.sv
// Bench for yutorina_bus_arbiter: two instances (no hold limit, hold limit 4)
// driven by shared directed and random stimulus, checked against a queue-free
// round-robin reference model every cycle.
module tb_yutorina_bus_arbiter;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [3:0]    m_req_, m_as_, m_rw;
   logic [119:0]  m_addr;
   logic [127:0]  m_w_data;
   logic          s_rdy_;

   logic [3:0]    grnt_o [2];
   logic [3:0]    rdy_o  [2];
   logic [29:0]   saddr_o[2];
   logic [31:0]   swd_o  [2];
   logic          sas_o  [2];
   logic          srw_o  [2];
   logic [1:0]    own_o  [2];
   logic          busy_o [2];

   int checks = 0;
   int errors = 0;

   bit m_owned[2];
   int m_own  [2];
   int m_hold [2];

   always #5 clk = ~clk;

   yutorina_bus_arbiter #(.NUM_M(4), .ADDR_W(30), .DATA_W(32), .MAX_HOLD(0)) dut0 (
      .clk(clk), .rst_n(rst_n), .m_req_(m_req_), .m_grnt_(grnt_o[0]), .m_addr(m_addr),
      .m_as_(m_as_), .m_rw(m_rw), .m_w_data(m_w_data), .m_rdy_(rdy_o[0]),
      .s_addr(saddr_o[0]), .s_as_(sas_o[0]), .s_rw(srw_o[0]), .s_w_data(swd_o[0]),
      .s_rdy_(s_rdy_), .owner(own_o[0]), .busy(busy_o[0]));

   yutorina_bus_arbiter #(.NUM_M(4), .ADDR_W(30), .DATA_W(32), .MAX_HOLD(4)) dut4 (
      .clk(clk), .rst_n(rst_n), .m_req_(m_req_), .m_grnt_(grnt_o[1]), .m_addr(m_addr),
      .m_as_(m_as_), .m_rw(m_rw), .m_w_data(m_w_data), .m_rdy_(rdy_o[1]),
      .s_addr(saddr_o[1]), .s_as_(sas_o[1]), .s_rw(srw_o[1]), .s_w_data(swd_o[1]),
      .s_rdy_(s_rdy_), .owner(own_o[1]), .busy(busy_o[1]));

   task automatic check(input string name, input int d, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s dut%0d: got %0h expected %0h at %0t", name, d, act, exp, $time);
      end
   endtask

   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   // First requester after 'from', wrapping, with 'from' itself tried last.
   function automatic int search(input int from, input logic [3:0] req);
      for (int k = 1; k <= 4; k++) begin
         if (req[(from + k) % 4]) return (from + k) % 4;
      end
      return -1;
   endfunction

   // Reference model of ownership, updated at each clock edge.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int d = 0; d < 2; d++) begin
            m_owned[d] <= 1'b0;
            m_own[d]   <= 0;
            m_hold[d]  <= 0;
         end
      end else begin
         for (int d = 0; d < 2; d++) begin
            logic [3:0] req;
            bit oth, expired;
            int w, lim;
            lim = (d == 0) ? 0 : 4;
            req = ~m_req_;
            w   = search(m_own[d], req);
            oth = |(req & ~(4'b0001 << m_own[d]));
            if (!m_owned[d]) begin
               if (w >= 0) begin
                  m_owned[d] <= 1'b1;
                  m_own[d]   <= w;
                  m_hold[d]  <= 0;
               end
            end else begin
               expired = (lim > 0) && (m_hold[d] >= lim) && m_as_[m_own[d]] && oth;
               if (req[m_own[d]] && !expired) begin
                  if (oth) m_hold[d] <= m_hold[d] + 1;
               end else if (oth) begin
                  m_own[d]  <= w;
                  m_hold[d] <= 0;
               end else begin
                  m_owned[d] <= 1'b0;
                  m_hold[d]  <= 0;
               end
            end
         end
      end
   end

   // Compare every output of both instances against the model on the falling edge.
   always @(negedge clk) begin
      if (rst_n) begin
         for (int d = 0; d < 2; d++) begin
            logic [3:0] eg, er;
            int o;
            o  = m_own[d];
            eg = m_owned[d] ? ~(4'b0001 << o) : 4'b1111;
            er = 4'b1111;
            if (m_owned[d]) er[o] = s_rdy_;
            check("grnt", d, 64'(grnt_o[d]), 64'(eg));
            check("owner", d, 64'(own_o[d]), 64'(o));
            check("busy", d, 64'(busy_o[d]), 64'(m_owned[d]));
            check("rdy", d, 64'(rdy_o[d]), 64'(er));
            check("s_addr", d, 64'(saddr_o[d]), m_owned[d] ? 64'(m_addr[o*30 +: 30]) : 64'd0);
            check("s_wdata", d, 64'(swd_o[d]), m_owned[d] ? 64'(m_w_data[o*32 +: 32]) : 64'd0);
            check("s_as", d, 64'(sas_o[d]), m_owned[d] ? 64'(m_as_[o]) : 64'd1);
            check("s_rw", d, 64'(srw_o[d]), m_owned[d] ? 64'(m_rw[o]) : 64'd1);
         end
      end
   end

   initial begin
      int order [5];
      bit as_pat [7];
      order  = '{1, 2, 3, 0, 1};
      as_pat = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
      rst_n = 1'b0; m_req_ = 4'hF; m_as_ = 4'hF; m_rw = 4'hF;
      m_addr = '0; m_w_data = '0; s_rdy_ = 1'b1;
      #12;
      for (int d = 0; d < 2; d++) begin
         check("rst_grnt", d, 64'(grnt_o[d]), 64'hF);
         check("rst_sas", d, 64'(sas_o[d]), 64'd1);
         check("rst_owner", d, 64'(own_o[d]), 64'd0);
         check("rst_busy", d, 64'(busy_o[d]), 64'd0);
         check("rst_rdy", d, 64'(rdy_o[d]), 64'hF);
      end
      rst_n = 1'b1;

      // Single request from master 0 and one access to 0x100.
      m_req_ = 4'b1110;
      cycle();
      check("t1_grnt", 0, 64'(grnt_o[0]), 64'b1110);
      check("t1_owner", 0, 64'(own_o[0]), 64'd0);
      check("t1_busy", 0, 64'(busy_o[0]), 64'd1);
      m_addr[29:0] = 30'h100; m_as_ = 4'b1110; s_rdy_ = 1'b0;
      #1;
      check("t1_saddr", 0, 64'(saddr_o[0]), 64'h100);
      check("t1_rdy", 0, 64'(rdy_o[0]), 64'b1110);
      cycle();
      m_as_ = 4'hF; s_rdy_ = 1'b1; m_req_ = 4'hF;
      cycle();

      // All request out of reset: rotation 1,2,3,0,1 with no idle gap.
      rst_n = 1'b0; #1; rst_n = 1'b1;
      m_req_ = 4'b0000;
      cycle();
      check("t2_first", 0, 64'(own_o[0]), 64'd1);
      for (int i = 0; i < 4; i++) begin
         m_as_[order[i]] = 1'b0;
         cycle();
         m_as_[order[i]] = 1'b1;
         m_req_[order[i]] = 1'b1;
         cycle();
         m_req_[order[i]] = 1'b0;
         for (int d = 0; d < 2; d++) begin
            check("t2_order", d, 64'(own_o[d]), 64'(order[i + 1]));
            check("t2_busy", d, 64'(busy_o[d]), 64'd1);
         end
      end

      // Owner 1 releases on the same edge master 3 requests.
      m_req_ = 4'hF;
      cycle();
      m_req_ = 4'b1101;
      cycle();
      check("t3_owner", 0, 64'(own_o[0]), 64'd1);
      m_as_[1] = 1'b0;
      m_req_ = 4'b0111;
      cycle();
      check("t3_grnt", 0, 64'(grnt_o[0]), 64'b0111);
      check("t3_sas", 0, 64'(sas_o[0]), 64'd1);
      m_as_ = 4'hF; m_req_ = 4'hF;
      cycle();

      // Hold limit: master 0 keeps req_ low while master 2 waits.
      rst_n = 1'b0; #1; rst_n = 1'b1;
      m_req_ = 4'b1110;
      cycle();
      m_req_ = 4'b1010;
      for (int e = 0; e < 7; e++) begin
         m_as_[0] = as_pat[e];
         cycle();
         if (e == 5) check("t4_held", 1, 64'(own_o[1]), 64'd0);
         if (e == 6) begin
            check("t4_moved", 1, 64'(own_o[1]), 64'd2);
            check("t4_grnt", 1, 64'(grnt_o[1]), 64'b1011);
            check("t4_nolimit", 0, 64'(own_o[0]), 64'd0);
         end
      end

      // No requests for ten cycles: idle with owners parked.
      m_as_ = 4'hF; m_req_ = 4'hF;
      repeat (10) cycle();
      for (int d = 0; d < 2; d++) begin
         check("t5_grnt", d, 64'(grnt_o[d]), 64'hF);
         check("t5_sas", d, 64'(sas_o[d]), 64'd1);
         check("t5_busy", d, 64'(busy_o[d]), 64'd0);
      end
      check("t5_owner", 0, 64'(own_o[0]), 64'd0);
      check("t5_owner", 1, 64'(own_o[1]), 64'd2);

      // Reset mid-transfer while master 2 owns the bus.
      m_req_ = 4'b1011;
      cycle();
      m_as_[2] = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      for (int d = 0; d < 2; d++) begin
         check("t6_grnt", d, 64'(grnt_o[d]), 64'hF);
         check("t6_sas", d, 64'(sas_o[d]), 64'd1);
         check("t6_owner", d, 64'(own_o[d]), 64'd0);
      end
      m_as_ = 4'hF; rst_n = 1'b1; m_req_ = 4'b1110;
      cycle();
      for (int d = 0; d < 2; d++) check("t6_regrant", d, 64'(grnt_o[d]), 64'b1110);

      // Random traffic with sticky requests so the hold limit gets exercised.
      for (int c = 0; c < 3000; c++) begin
         for (int i = 0; i < 4; i++) begin
            if ($urandom_range(3) == 0) m_req_[i] = ~m_req_[i];
            m_addr[i*30 +: 30]   = 30'($urandom);
            m_w_data[i*32 +: 32] = $urandom;
         end
         m_as_  = 4'($urandom);
         m_rw   = 4'($urandom);
         s_rdy_ = 1'($urandom);
         cycle();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
